writeback_queue: RTL and testbench

//  Parametrised write-back stage. Accepts retiring instructions from the execute/memory stage,

---
 rtl/writeback_queue_pkg.sv | 40 ++++
 rtl/writeback_queue_if.sv | 33 +++
 rtl/writeback_queue_wb_fifo.sv | 62 ++++++
 rtl/writeback_queue.sv | 119 +++++++++++
 tb/tb_writeback_queue.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/writeback_queue_pkg.sv
// Shared decode constants for the write-back queue.
// Opcode values, result-source encoding and the opcode-to-source decoder.
package writeback_queue_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_MEM,
    SRC_LINK
  } src_e;

  // rd==0 never produces an entry: x0 is not writable.
  function automatic src_e decode_src(
    input logic [6:0] opc,
    input logic [4:0] rd
  );
    src_e src;
    unique case (1'b1)
      (opc == OPC_OP),
      (opc == OPC_OP_IMM): src = SRC_ALU;
      (opc == OPC_LOAD):   src = SRC_MEM;
      (opc == OPC_JAL),
      (opc == OPC_JALR):   src = SRC_LINK;
      (opc == OPC_STORE),
      (opc == OPC_BRANCH): src = SRC_NONE;
      default:             src = SRC_NONE;
    endcase
    if (rd == 5'd0) src = SRC_NONE;
    return src;
  endfunction

endpackage

// File: rtl/writeback_queue_if.sv
// Retire-side and register-file-side handshake bundle.
// master: environment (upstream + regfile); slave: the queue.
interface writeback_queue_if #(
  parameter int XLEN = 32
);

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_ir;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_alu;
  logic [XLEN-1:0] in_mem;

  logic            rf_we;
  logic            rf_ready;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  modport master (
    output in_valid, in_ir, in_pc,
    output in_alu, in_mem, rf_ready,
    input  in_ready, rf_we,
    input  rf_waddr, rf_wdata
  );

  modport slave (
    input  in_valid, in_ir, in_pc,
    input  in_alu, in_mem, rf_ready,
    output in_ready, rf_we,
    output rf_waddr, rf_wdata
  );

endinterface

// File: rtl/writeback_queue_wb_fifo.sv
// Generic DEPTH x WIDTH register FIFO with count and exposed storage.
// Ports: clk, reset, flush, push, pop, wdata, rdata, count, full, empty, head_ptr, entries.
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = PW + 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            wdata,
  output logic [WIDTH-1:0]            rdata,
  output logic [CW-1:0]               count,
  output logic                        full,
  output logic                        empty,
  output logic [PW-1:0]               head_ptr,
  output logic [DEPTH-1:0][WIDTH-1:0] entries
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               head;
  logic [PW-1:0]               tail;
  logic                        do_push;
  logic                        do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign rdata    = mem[head];
  assign head_ptr = head;
  assign entries  = mem;

  // Pointers are PW bits wide, so DEPTH being
  // a power of two makes them wrap for free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[tail] <= wdata;
        tail      <= tail + 1'b1;
      end
      if (do_pop)
        head <= head + 1'b1;
      count <= count + CW'(do_push)
                     - CW'(do_pop);
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// In-order write-back queue: result select, regfile drain, forwarding, retire count.
// Ports: clk, reset, flush, bus (slave), fwd_raddr, fwd_hit, fwd_data, retired.
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 4,
  parameter int PC_STEP = 1,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  writeback_queue_if.slave bus,
  input  logic [4:0]       fwd_raddr,
  output logic             fwd_hit,
  output logic [XLEN-1:0]  fwd_data,
  output logic [CNT_W-1:0] retired
);

  localparam int W  = 5 + XLEN;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0)
  begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end

  src_e                    src;
  logic [XLEN-1:0]         link;
  logic [XLEN-1:0]         result;
  logic                    accept;
  logic                    push;
  logic                    pop;
  logic [W-1:0]            entry_in;
  logic [W-1:0]            head;
  logic [CW-1:0]           count;
  logic                    full;
  logic                    empty;
  logic [PW-1:0]           head_ptr;
  logic [DEPTH-1:0][W-1:0] entries;
  logic [PW-1:0]           idx;
  logic                    unused_ir;

  assign unused_ir = ^bus.in_ir[31:12];

  assign src  = decode_src(bus.in_ir[6:0],
                           bus.in_ir[11:7]);
  assign link = bus.in_pc + XLEN'(PC_STEP);

  always_comb begin
    result = '0;
    unique case (src)
      SRC_ALU:  result = bus.in_alu;
      SRC_MEM:  result = bus.in_mem;
      SRC_LINK: result = link;
      default:  result = '0;
    endcase
  end

  // in_ready depends on stored count only, so
  // a pop cannot open a slot in the same cycle.
  assign bus.in_ready = !full;
  assign accept   = bus.in_valid && bus.in_ready;
  assign push     = accept && (src != SRC_NONE);
  assign pop      = bus.rf_we && bus.rf_ready;
  assign entry_in = {bus.in_ir[11:7], result};

  wb_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .push     (push),
    .pop      (pop),
    .wdata    (entry_in),
    .rdata    (head),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .head_ptr (head_ptr),
    .entries  (entries)
  );

  assign bus.rf_we    = !empty;
  assign bus.rf_waddr = empty ? 5'd0
                              : head[W-1:XLEN];
  assign bus.rf_wdata = empty ? '0
                              : head[XLEN-1:0];

  // Walk oldest to youngest; later matches
  // override, leaving the youngest hit.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_ptr + PW'(i);
      if (CW'(i) < count &&
          fwd_raddr != 5'd0 &&
          entries[idx][W-1:XLEN] == fwd_raddr)
      begin
        fwd_hit  = 1'b1;
        fwd_data = entries[idx][XLEN-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      retired <= '0;
    else if (accept)
      retired <= retired + CNT_W'(1);
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue: directed scenarios then random traffic.
// A queue-based reference model predicts drain order, forwarding and retire count.
module tb_writeback_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 32;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             flush = 1'b0;
  logic [4:0]       fwd_raddr = 5'd0;
  logic             fwd_hit;
  logic [XLEN-1:0]  fwd_data;
  logic [CNT_W-1:0] retired;

  writeback_queue_if #(.XLEN(XLEN)) bus ();

  writeback_queue #(
    .XLEN    (XLEN),
    .DEPTH   (DEPTH),
    .PC_STEP (1),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .bus       (bus),
    .fwd_raddr (fwd_raddr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  exp_t             q[$];
  logic [CNT_W-1:0] ret_m = '0;
  int               checks = 0;
  int               errors = 0;

  task automatic chk(string name,
                     logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  // Reference: which instructions write back, and with what.
  function automatic bit model_result(
    input  logic [31:0]     ir,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] alu,
    input  logic [XLEN-1:0] mem,
    output exp_t            e
  );
    e.rd   = ir[11:7];
    e.data = '0;
    if (ir[11:7] == 5'd0) return 1'b0;
    case (ir[6:0])
      7'h33, 7'h13: e.data = alu;
      7'h03:        e.data = mem;
      7'h6f, 7'h67: e.data = pc + 32'd1;
      default:      return 1'b0;
    endcase
    return 1'b1;
  endfunction

  // Monitor + model: checks at the falling edge, then
  // predicts what the next rising edge will do.
  always begin : monitor
    exp_t            e;
    bit              enq;
    bit              xfer;
    bit              full_m;
    logic            hit_m;
    logic [XLEN-1:0] fd_m;
    @(negedge clk or posedge reset);
    if (reset) begin
      q.delete();
      ret_m = '0;
      #1;
      chk("reset rf_we", 64'(bus.rf_we), 64'd0);
      chk("reset rf_waddr", 64'(bus.rf_waddr), 64'd0);
      chk("reset rf_wdata", 64'(bus.rf_wdata), 64'd0);
      chk("reset retired", 64'(retired), 64'd0);
      chk("reset in_ready", 64'(bus.in_ready), 64'd1);
      chk("reset fwd_hit", 64'(fwd_hit), 64'd0);
    end else begin
      chk("rf_we", 64'(bus.rf_we), 64'(q.size() != 0));
      if (q.size() != 0) begin
        chk("rf_waddr", 64'(bus.rf_waddr), 64'(q[0].rd));
        chk("rf_wdata", 64'(bus.rf_wdata), 64'(q[0].data));
      end
      chk("in_ready", 64'(bus.in_ready),
          64'(q.size() < DEPTH));
      chk("retired", 64'(retired), 64'(ret_m));
      hit_m = 1'b0;
      fd_m  = '0;
      if (fwd_raddr != 5'd0)
        foreach (q[i])
          if (q[i].rd == fwd_raddr) begin
            hit_m = 1'b1;
            fd_m  = q[i].data;
          end
      chk("fwd_hit", 64'(fwd_hit), 64'(hit_m));
      chk("fwd_data", 64'(fwd_data), 64'(fd_m));
      full_m = (q.size() == DEPTH);
      #1;
      xfer = bus.in_valid && !full_m;
      enq  = model_result(bus.in_ir, bus.in_pc,
                          bus.in_alu, bus.in_mem, e);
      if (xfer) ret_m = ret_m + 1'b1;
      if (flush) q.delete();
      else begin
        if (q.size() != 0 && bus.rf_ready)
          void'(q.pop_front());
        if (xfer && enq) q.push_back(e);
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(logic [6:0] opc, logic [4:0] rd,
                       logic [31:0] pc, logic [31:0] alu,
                       logic [31:0] mem);
    logic [19:0] hi;
    hi = 20'($urandom);
    bus.in_ir  = {hi, rd, opc};
    bus.in_pc  = pc;
    bus.in_alu = alu;
    bus.in_mem = mem;
  endtask

  task automatic send(logic [6:0] opc, logic [4:0] rd,
                      logic [31:0] pc, logic [31:0] alu,
                      logic [31:0] mem);
    bit ok;
    ok = 1'b0;
    drive(opc, rd, pc, alu, mem);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      $display("FAIL send timeout: in_ready 0 expected 1");
      $fatal(1, "handshake timeout");
    end
  endtask

  logic [6:0] opcs [8] = '{7'h33, 7'h13, 7'h03, 7'h6f,
                           7'h67, 7'h23, 7'h63, 7'h37};

  initial begin : stim
    bus.in_valid = 1'b0;
    bus.in_ir    = '0;
    bus.in_pc    = '0;
    bus.in_alu   = '0;
    bus.in_mem   = '0;
    bus.rf_ready = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    step(1);

    // single R-type
    bus.rf_ready = 1'b1;
    send(7'h33, 5'd5, 32'h0, 32'h1234, 32'h0);
    step(2);

    // JAL link, LOAD data, STORE (no entry)
    send(7'h6f, 5'd1, 32'h40, 32'h9, 32'h9);
    send(7'h03, 5'd2, 32'h0, 32'h7, 32'hDEAD);
    send(7'h23, 5'd7, 32'h0, 32'h5, 32'h6);
    step(3);

    // fill to full while stalled, then drain
    bus.rf_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(7'h13, 5'(i + 10), 32'h0,
           32'h100 + 32'(i), 32'h0);
    step(2);
    bus.rf_ready = 1'b1;
    step(6);

    // forwarding picks youngest of duplicate rd
    bus.rf_ready = 1'b0;
    send(7'h13, 5'd3, 32'h0, 32'hA, 32'h0);
    send(7'h13, 5'd3, 32'h0, 32'hB, 32'h0);
    fwd_raddr = 5'd3;
    step(2);
    fwd_raddr = 5'd0;
    step(1);
    bus.rf_ready = 1'b1;
    step(4);

    // steady push+pop at count 2 across wrap
    bus.rf_ready = 1'b0;
    send(7'h33, 5'd20, 32'h0, 32'h200, 32'h0);
    send(7'h33, 5'd21, 32'h0, 32'h201, 32'h0);
    bus.rf_ready = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(7'h33, 5'(i % 7 + 1), 32'h0,
            32'h300 + 32'(i), 32'h0);
      fwd_raddr = 5'(i % 7 + 1);
      step(1);
    end
    bus.in_valid = 1'b0;
    step(5);

    // flush with 3 queued and a concurrent transfer
    bus.rf_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(7'h33, 5'(i + 4), 32'h0, 32'h400 + 32'(i), 32'h0);
    drive(7'h33, 5'd9, 32'h0, 32'h499, 32'h0);
    bus.in_valid = 1'b1;
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    step(2);

    // reset in the middle of a drain
    for (int i = 0; i < 3; i++)
      send(7'h67, 5'(i + 12), 32'h50 + 32'(i), 32'h0, 32'h0);
    bus.rf_ready = 1'b1;
    step(1);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(2);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      drive(opcs[$urandom_range(0, 7)],
            5'($urandom_range(0, 7)),
            ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF
                                         : $urandom,
            $urandom, $urandom);
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.rf_ready = ($urandom_range(0, 2) != 0);
      flush        = ($urandom_range(0, 39) == 0);
      fwd_raddr    = 5'($urandom_range(0, 7));
      step(1);
    end
    bus.in_valid = 1'b0;
    flush        = 1'b0;
    bus.rf_ready = 1'b1;
    step(10);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

endmodule
